// File: rtl/cmos_nvram_arbiter.sv
// Shares one single-port CMOS RAM between the game CPU and the HPS ioctl NVRAM channel (round-robin).
// Latency from grant: write completes 2 cycles later, read 3 cycles later (RAM has 1-cycle read).
// Backpressure: CPU held off until the cpu_ack pulse; host stalled by ioctl_wait while an access is pending.
module cmos_nvram_arbiter #(
    parameter int AW    = 10,
    parameter int DW    = 4,
    parameter int DEPTH = 1024
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    input  logic          nv_sel,
    input  logic          ioctl_wr,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {S_IDLE, S_CPU_ACC, S_HPS_ACC, S_RD_DATA} state_t;

    localparam logic [24:0] LP_DEPTH = 25'(DEPTH);

    state_t        r_state;
    state_t        w_next;
    logic          r_last_hps;
    logic          r_rd_hps;
    logic          r_cpu_we;
    logic [AW-1:0] r_cpu_addr;
    logic [DW-1:0] r_cpu_din;
    logic [DW-1:0] r_cpu_dout;
    logic          r_cpu_ack;
    logic          r_pend;
    logic          r_oor;
    logic          r_h_we;
    logic [AW-1:0] r_h_addr;
    logic [DW-1:0] r_h_dat;
    logic [7:0]    r_ioctl_din;

    logic          w_cpu_req;
    logic          w_hps_req;
    logic          w_grant_cpu;
    logic          w_grant_hps;
    logic          w_host_stb;
    logic          w_hps_done;
    logic [AW-1:0] w_ram_addr;
    logic          w_ram_we;
    logic [DW-1:0] w_ram_din;
    logic [7:0]    w_din_ext;
    logic          w_unused;

    // The request that was just acknowledged is masked for one cycle so a held
    // cpu_req is not served twice; the next request is sampled after the ack.
    assign w_cpu_req  = cpu_req & ~r_cpu_ack;
    // Out-of-range host accesses never compete for the RAM.
    assign w_hps_req  = r_pend & ~r_oor;
    assign w_host_stb = nv_sel & (ioctl_wr | ioctl_rd);
    assign w_unused   = ^ioctl_dout;

    // Host read byte: upper bits forced to 1s, RAM word in the low bits.
    always_comb begin
        w_din_ext           = 8'hFF;
        w_din_ext[DW-1:0]   = ram_dout;
    end

    // Next-state, grant and RAM port drive.
    always_comb begin
        w_next      = r_state;
        w_grant_cpu = 1'b0;
        w_grant_hps = 1'b0;
        w_ram_addr  = '0;
        w_ram_we    = 1'b0;
        w_ram_din   = '0;
        w_hps_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cpu_req && w_hps_req) begin
                    w_grant_cpu = r_last_hps;
                    w_grant_hps = ~r_last_hps;
                end else begin
                    w_grant_cpu = w_cpu_req;
                    w_grant_hps = w_hps_req;
                end
                if (w_grant_cpu)      w_next = S_CPU_ACC;
                else if (w_grant_hps) w_next = S_HPS_ACC;
            end
            S_CPU_ACC: begin
                w_ram_addr = r_cpu_addr;
                w_ram_we   = r_cpu_we;
                w_ram_din  = r_cpu_din;
                w_next     = r_cpu_we ? S_IDLE : S_RD_DATA;
            end
            S_HPS_ACC: begin
                w_ram_addr = r_h_addr;
                w_ram_we   = r_h_we;
                w_ram_din  = r_h_dat;
                w_hps_done = r_h_we;
                w_next     = r_h_we ? S_IDLE : S_RD_DATA;
            end
            S_RD_DATA: begin
                w_hps_done = r_rd_hps;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Reset kills the write strobe immediately, so an aborted write never lands.
    assign ram_we     = w_ram_we & reset_n;
    assign ram_addr   = w_ram_addr;
    assign ram_din    = w_ram_din;
    assign cpu_ack    = r_cpu_ack;
    assign cpu_dout   = r_cpu_dout;
    assign ioctl_wait = r_pend;
    assign ioctl_din  = r_ioctl_din;

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Grant bookkeeping: remember the winner, freeze the CPU command, track read owner.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_last_hps <= 1'b1;
            r_rd_hps   <= 1'b0;
            r_cpu_we   <= 1'b0;
            r_cpu_addr <= '0;
            r_cpu_din  <= '0;
        end else begin
            if (w_grant_cpu) begin
                r_last_hps <= 1'b0;
                r_cpu_we   <= cpu_we;
                r_cpu_addr <= cpu_addr;
                r_cpu_din  <= cpu_din;
            end else if (w_grant_hps) begin
                r_last_hps <= 1'b1;
            end
            if (r_state == S_CPU_ACC)      r_rd_hps <= 1'b0;
            else if (r_state == S_HPS_ACC) r_rd_hps <= 1'b1;
        end
    end

    // CPU completion: ack one cycle after the write cycle or after read data returns.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_ack  <= 1'b0;
            r_cpu_dout <= '0;
        end else begin
            r_cpu_ack <= ((r_state == S_CPU_ACC) && r_cpu_we) ||
                         ((r_state == S_RD_DATA) && !r_rd_hps);
            if ((r_state == S_RD_DATA) && !r_rd_hps) r_cpu_dout <= ram_dout;
        end
    end

    // Host pending buffer: one access at a time; strobes while busy are dropped.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_pend   <= 1'b0;
            r_oor    <= 1'b0;
            r_h_we   <= 1'b0;
            r_h_addr <= '0;
            r_h_dat  <= '0;
        end else if (r_pend) begin
            if (r_oor || w_hps_done) r_pend <= 1'b0;
        end else if (w_host_stb) begin
            r_pend   <= 1'b1;
            r_oor    <= !(ioctl_addr < LP_DEPTH);
            r_h_we   <= ioctl_wr;
            r_h_addr <= ioctl_addr[AW-1:0];
            r_h_dat  <= ioctl_dout[DW-1:0];
        end
    end

    // Host read data: RAM word padded with 1s, or all 1s for an out-of-range read.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ioctl_din <= 8'hFF;
        end else if ((r_state == S_RD_DATA) && r_rd_hps) begin
            r_ioctl_din <= w_din_ext;
        end else if (r_pend && r_oor && !r_h_we) begin
            r_ioctl_din <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_cmos_nvram_arbiter.sv
`timescale 1ns/1ps
module tb_cmos_nvram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [3:0]  cpu_din = '0;
    logic [3:0]  cpu_dout;
    logic        cpu_ack;
    logic        nv_sel = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [3:0]  ram_din;
    logic [3:0]  ram_dout;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int we_log[$];
    logic [3:0] mem [0:1023];

    cmos_nvram_arbiter #(.AW(10), .DW(4), .DEPTH(1024)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .nv_sel(nv_sel), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    // Single-port RAM with registered read.
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Record every RAM write cycle by address.
    always @(negedge clk_sys) begin
        if (ram_we) begin
            we_log.push_back(int'(ram_addr));
            we_cnt++;
        end
    end

    function automatic logic [3:0] fill_pat(input int k);
        fill_pat = 4'((k * 7 + 3) & 15);
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic host_access(input logic wr, input logic [24:0] addr, input logic [7:0] data,
                               output logic [7:0] rdata, output int wcyc);
        nv_sel = 1'b1; ioctl_addr = addr; ioctl_dout = data;
        ioctl_wr = wr; ioctl_rd = ~wr;
        tick();
        ioctl_wr = 1'b0; ioctl_rd = 1'b0;
        wcyc = 0;
        while (ioctl_wait && wcyc < 20) begin
            wcyc++;
            tick();
        end
        rdata = ioctl_din;
    endtask

    task automatic cpu_access(input logic we, input logic [9:0] addr, input logic [3:0] din,
                              output logic [3:0] dout, output int lat);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (cpu_ack) begin
                lat = k;
                break;
            end
        end
        dout = cpu_dout;
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        checks++; if (cpu_ack !== 1'b0)     begin errors++; $display("FAIL reset cpu_ack got %b want 0", cpu_ack); end
        checks++; if (cpu_dout !== 4'h0)    begin errors++; $display("FAIL reset cpu_dout got %h want 0", cpu_dout); end
        checks++; if (ioctl_wait !== 1'b0)  begin errors++; $display("FAIL reset ioctl_wait got %b want 0", ioctl_wait); end
        checks++; if (ioctl_din !== 8'hFF)  begin errors++; $display("FAIL reset ioctl_din got %h want ff", ioctl_din); end
        checks++; if (ram_we !== 1'b0)      begin errors++; $display("FAIL reset ram_we got %b want 0", ram_we); end
        checks++; if (ram_addr !== 10'h0)   begin errors++; $display("FAIL reset ram_addr got %h want 0", ram_addr); end
        checks++; if (ram_din !== 4'h0)     begin errors++; $display("FAIL reset ram_din got %h want 0", ram_din); end
        reset_n = 1'b1;
        tick(); tick();
    endtask

    // Host pending and CPU requesting in the same IDLE cycle: CPU wins first after reset.
    task automatic test_first_contest();
        int ack_k = -1;
        int drop_k = -1;
        we_log.delete();
        nv_sel = 1'b1; ioctl_addr = 25'h030; ioctl_dout = 8'h0C; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h031; cpu_din = 4'h3;
        for (int k = 0; k < 12; k++) begin
            if (cpu_ack && ack_k < 0) begin ack_k = k; cpu_req = 1'b0; end
            if (!ioctl_wait && drop_k < 0) drop_k = k;
            tick();
        end
        checks++; if (ack_k !== 2)  begin errors++; $display("FAIL contest cpu_ack cycle got %0d want 2", ack_k); end
        checks++; if (drop_k !== 4) begin errors++; $display("FAIL contest wait drop cycle got %0d want 4", drop_k); end
        checks++; if (we_log.size() !== 2) begin errors++; $display("FAIL contest write count got %0d want 2", we_log.size()); end
        else begin
            checks++; if (we_log[0] !== 'h031) begin errors++; $display("FAIL contest first grant addr got %h want 031", we_log[0]); end
            checks++; if (we_log[1] !== 'h030) begin errors++; $display("FAIL contest second grant addr got %h want 030", we_log[1]); end
        end
        checks++; if (mem[10'h030] !== 4'hC) begin errors++; $display("FAIL contest host data got %h want c", mem[10'h030]); end
        checks++; if (mem[10'h031] !== 4'h3) begin errors++; $display("FAIL contest cpu data got %h want 3", mem[10'h031]); end
    endtask

    task automatic test_cpu_rw();
        logic [3:0] d;
        int lat;
        int c0;
        c0 = we_cnt;
        cpu_access(1'b1, 10'h3A5, 4'h9, d, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL cpu_write latency got %0d want 2", lat); end
        checks++; if (we_cnt - c0 !== 1) begin errors++; $display("FAIL cpu_write ram_we cycles got %0d want 1", we_cnt - c0); end
        checks++; if (mem[10'h3A5] !== 4'h9) begin errors++; $display("FAIL cpu_write ram word got %h want 9", mem[10'h3A5]); end
        cpu_access(1'b0, 10'h3A5, 4'h0, d, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL cpu_read latency got %0d want 3", lat); end
        checks++; if (d !== 4'h9) begin errors++; $display("FAIL cpu_read data got %h want 9", d); end
        checks++; if (we_cnt - c0 !== 1) begin errors++; $display("FAIL cpu_read ram_we cycles got %0d want 1", we_cnt - c0); end
    endtask

    // Request dropped after one cycle and address changed: the write still lands, ack still pulses.
    task automatic test_cpu_abandon();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h155; cpu_din = 4'h6;
        tick();
        cpu_req = 1'b0; cpu_addr = 10'h000; cpu_din = 4'h0;
        checks++; if (ram_we !== 1'b1)       begin errors++; $display("FAIL abandon ram_we got %b want 1", ram_we); end
        checks++; if (ram_addr !== 10'h155)  begin errors++; $display("FAIL abandon ram_addr got %h want 155", ram_addr); end
        tick();
        checks++; if (cpu_ack !== 1'b1)      begin errors++; $display("FAIL abandon cpu_ack got %b want 1", cpu_ack); end
        tick();
        checks++; if (cpu_ack !== 1'b0)      begin errors++; $display("FAIL abandon ack width got %b want 0", cpu_ack); end
        checks++; if (mem[10'h155] !== 4'h6) begin errors++; $display("FAIL abandon ram word got %h want 6", mem[10'h155]); end
    endtask

    task automatic test_download();
        logic [7:0] rd;
        int wc;
        for (int k = 0; k < 1024; k++) begin
            host_access(1'b1, 25'(k), 8'(k), rd, wc);
            checks++; if (wc !== 2) begin errors++; $display("FAIL download wait addr %0d got %0d want 2", k, wc); end
        end
        for (int k = 0; k < 1024; k++) begin
            checks++; if (mem[k] !== 4'(k)) begin errors++; $display("FAIL download word %0d got %h want %h", k, mem[k], 4'(k)); end
        end
    endtask

    task automatic test_upload();
        logic [3:0] d;
        logic [7:0] rd;
        int lat;
        int wc;
        for (int k = 0; k < 1024; k++) begin
            cpu_access(1'b1, 10'(k), fill_pat(k), d, lat);
            checks++; if (lat !== 2) begin errors++; $display("FAIL fill latency addr %0d got %0d want 2", k, lat); end
        end
        for (int k = 0; k < 1024; k++) begin
            host_access(1'b0, 25'(k), 8'h00, rd, wc);
            checks++; if (rd !== {4'hF, fill_pat(k)}) begin errors++; $display("FAIL upload addr %0d got %h want %h", k, rd, {4'hF, fill_pat(k)}); end
            checks++; if (wc !== 3) begin errors++; $display("FAIL upload wait addr %0d got %0d want 3", k, wc); end
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] rd;
        int wc;
        int c0;
        c0 = we_cnt;
        host_access(1'b1, 25'h400, 8'h5A, rd, wc);
        checks++; if (wc !== 1) begin errors++; $display("FAIL oor_write wait got %0d want 1", wc); end
        host_access(1'b0, 25'h001, 8'h00, rd, wc);
        checks++; if (rd !== 8'hFA) begin errors++; $display("FAIL oor_pre read got %h want fa", rd); end
        host_access(1'b0, 25'h7FF, 8'h00, rd, wc);
        checks++; if (wc !== 1) begin errors++; $display("FAIL oor_read wait got %0d want 1", wc); end
        checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL oor_read data got %h want ff", rd); end
        checks++; if (we_cnt !== c0) begin errors++; $display("FAIL oor ram_we count got %0d want %0d", we_cnt, c0); end
        checks++; if (mem[0] !== fill_pat(0)) begin errors++; $display("FAIL oor alias word0 got %h want %h", mem[0], fill_pat(0)); end
        // Strobe without nv_sel is ignored.
        nv_sel = 1'b0; ioctl_addr = 25'h002; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL unselected wait got %b want 0", ioctl_wait); end
        tick(); tick();
        checks++; if (we_cnt !== c0) begin errors++; $display("FAIL unselected ram_we count got %0d want %0d", we_cnt, c0); end
    endtask

    // CPU holds its request across acks while the host strobes again as soon as wait drops.
    task automatic test_back_to_back();
        logic [7:0] rd;
        int wc;
        tick(); tick();
        we_log.delete();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h010; cpu_din = 4'h7;
        for (int i = 0; i < 8; i++) begin
            host_access(1'b1, 25'(32 + i), 8'(i), rd, wc);
            checks++; if (wc !== 3) begin errors++; $display("FAIL alternate wait round %0d got %0d want 3", i, wc); end
        end
        cpu_req = 1'b0;
        tick(); tick(); tick();
        checks++; if (we_log.size() !== 16) begin errors++; $display("FAIL alternate grant count got %0d want 16", we_log.size()); end
        else begin
            for (int g = 0; g < 16; g++) begin
                int exp_a;
                exp_a = (g % 2 == 0) ? 'h010 : (32 + g / 2);
                checks++; if (we_log[g] !== exp_a) begin errors++; $display("FAIL alternate grant %0d addr got %h want %h", g, we_log[g], exp_a); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] d;
        logic [7:0] rd;
        int lat;
        int wc;
        cpu_access(1'b1, 10'h3A5, 4'h9, d, lat);
        cpu_access(1'b0, 10'h3A5, 4'h0, d, lat);
        checks++; if (d !== 4'h9) begin errors++; $display("FAIL midreset pre cpu read got %h want 9", d); end
        host_access(1'b0, 25'h3A5, 8'h00, rd, wc);
        checks++; if (rd !== 8'hF9) begin errors++; $display("FAIL midreset pre host read got %h want f9", rd); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checks++; if (cpu_ack !== 1'b0)    begin errors++; $display("FAIL midreset cpu_ack got %b want 0", cpu_ack); end
        checks++; if (cpu_dout !== 4'h0)   begin errors++; $display("FAIL midreset cpu_dout got %h want 0", cpu_dout); end
        checks++; if (ioctl_din !== 8'hFF) begin errors++; $display("FAIL midreset ioctl_din got %h want ff", ioctl_din); end
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL midreset ioctl_wait got %b want 0", ioctl_wait); end
        checks++; if (ram_we !== 1'b0)     begin errors++; $display("FAIL midreset ram_we got %b want 0", ram_we); end
        cpu_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        cpu_access(1'b0, 10'h3A5, 4'h0, d, lat);
        checks++; if (lat !== 3)  begin errors++; $display("FAIL postreset read latency got %0d want 3", lat); end
        checks++; if (d !== 4'h9) begin errors++; $display("FAIL postreset read data got %h want 9", d); end
        host_access(1'b0, 25'h155, 8'h00, rd, wc);
        checks++; if (rd !== 8'hF6) begin errors++; $display("FAIL postreset host read got %h want f6", rd); end
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 4'h0;
        ram_dout = 4'h0;
        test_reset();
        test_first_contest();
        test_cpu_rw();
        test_cpu_abandon();
        test_download();
        test_upload();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
